// File: rtl/draw_bg_scroll_if.sv
// -----------------------------------------------------------------------------
// vga_if : VGA timing bundle shared by the stages of the draw pipeline.
//
// Signals
//   hcount[10:0]  horizontal pixel counter
//   vcount[10:0]  vertical line counter
//   hsync, vsync  sync pulses (passed through untouched)
//   hblnk, vblnk  blanking flags
//   rgb[11:0]     4:4:4 pixel colour
//
// Modports
//   in   : consumer view of the timing fields (rgb is not consumed)
//   out  : producer view of timing fields plus rgb
// -----------------------------------------------------------------------------
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bg_scroll.sv
// -----------------------------------------------------------------------------
// draw_bg_scroll : horizontally scrolling, nearest-neighbour upscaled
// background stage at the head of the VGA draw chain.
//
// An IMG_W x IMG_H image held in image_rom is stretched onto a
// SCREEN_W x SCREEN_H raster. Image coordinates are tracked with running
// remainders (no dividers, no multipliers). A horizontal offset, advanced
// once per frame at the rising edge of vblnk, wraps the image sideways.
//
// Ports
//   clk            pixel clock
//   rst            asynchronous active-high reset
//   scroll_en      enables the per-frame offset advance (sampled at vblnk rise)
//   vin            vga_if.in  timing input
//   vout           vga_if.out timing delayed by 2 cycles plus rgb
//   scroll_offset  current horizontal offset in image pixels
//
// Build option
//   DRAW_BG_DEBUG_GRID_EN : when defined, pixels whose scrolled image column
//   or image row is a multiple of 32 are painted 12'hF0F. Otherwise the
//   output is pure image data and no grid logic exists.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// image_rom : background image store with a registered address. Data for an
// address presented on cycle N is valid during cycle N+1. The contents are a
// fixed generated pattern: data = a[11:0] ^ a[23:12] ^ 12'h5A5.
// -----------------------------------------------------------------------------
module image_rom #(
    parameter  int WIDTH  = 320,
    parameter  int HEIGHT = 240,
    localparam int AW     = ((WIDTH * HEIGHT) > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic [11:0]   data_o
);

    logic [AW-1:0] addr_q;

    function automatic logic [11:0] rom_word(input logic [AW-1:0] a);
        logic [23:0] w;
        w = 24'(a);
        return w[11:0] ^ w[23:12] ^ 12'h5A5;
    endfunction

    // Address register: the single cycle of read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= {AW{1'b0}};
        end else begin
            addr_q <= addr_i;
        end
    end

    assign data_o = rom_word(addr_q);

endmodule

module draw_bg_scroll #(
    parameter  int SCREEN_W    = 1024,
    parameter  int SCREEN_H    = 768,
    parameter  int IMG_W       = 320,
    parameter  int IMG_H       = 240,
    parameter  int SCROLL_STEP = 1,
    localparam int OFF_W       = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scroll_en,
    vga_if.in                vin,
    vga_if.out               vout,
    output logic [OFF_W-1:0] scroll_offset
);

    localparam int AW    = ((IMG_W * IMG_H) > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int ACC_W = 16;

    localparam logic [ACC_W-1:0] SW_ACC   = ACC_W'(SCREEN_W);
    localparam logic [ACC_W-1:0] SH_ACC   = ACC_W'(SCREEN_H);
    localparam logic [ACC_W-1:0] IW_ACC   = ACC_W'(IMG_W);
    localparam logic [ACC_W-1:0] IH_ACC   = ACC_W'(IMG_H);
    localparam logic [10:0]      SW_CNT   = 11'(SCREEN_W);
    localparam logic [10:0]      SH_CNT   = 11'(SCREEN_H);
    localparam logic [AW-1:0]    IW_ADR   = AW'(IMG_W);
    localparam logic [AW:0]      IW_SX    = (AW + 1)'(IMG_W);
    localparam logic [OFF_W:0]   IW_OFF   = (OFF_W + 1)'(IMG_W);
    localparam logic [OFF_W:0]   STEP_OFF = (OFF_W + 1)'(SCROLL_STEP);
    localparam logic [AW-1:0]    ONE_ADR  = AW'(1'b1);

    // Horizontal accumulator state: values for the pixel after the current one.
    logic [ACC_W-1:0] xacc_q, xacc_d;
    logic [AW-1:0]    img_x_q, img_x_d;
    // Vertical accumulator state: values for the current line.
    logic [ACC_W-1:0] yacc_q, yacc_d;
    logic [AW-1:0]    img_y_q, img_y_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    // Set once a frame start has been seen since reset.
    logic             sync_valid_q, sync_valid_d;
    logic             vblnk_q;
    logic [OFF_W-1:0] scroll_offset_q, scroll_offset_d;

    // Stage 1 registers.
    logic [10:0] h1_q, v1_q;
    logic        hs1_q, vs1_q, hb1_q, vb1_q, black1_q;
    // Stage 2 registers (drive vout).
    logic [10:0] h2_q, v2_q;
    logic        hs2_q, vs2_q, hb2_q, vb2_q;
    logic [11:0] rgb2_q, rgb2_d;

    logic             h_zero_s, v_zero_s, h_in_s, v_in_s, frame_ok_s, black_s;
    logic [ACC_W-1:0] cur_xacc_s, x_sum_s;
    logic [AW-1:0]    cur_img_x_s;
    logic [ACC_W-1:0] y_sum_s, cur_yacc_s;
    logic [AW-1:0]    cur_img_y_s, cur_row_s;
    logic [AW:0]      sx_sum_s;
    logic [AW-1:0]    sx_s, addr_s;
    logic [OFF_W:0]   off_sum_s;
    logic             vb_rise_s;
    logic [11:0]      rom_data_s;

`ifdef DRAW_BG_DEBUG_GRID_EN
    logic grid_s;
    logic grid1_q;
`endif

    image_rom #(.WIDTH(IMG_W), .HEIGHT(IMG_H)) u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr_s),
        .data_o (rom_data_s)
    );

    // Raster position decode and the black-pixel decision.
    always_comb begin
        h_zero_s     = (vin.hcount == 11'd0);
        v_zero_s     = (vin.vcount == 11'd0);
        h_in_s       = (vin.hcount < SW_CNT);
        v_in_s       = (vin.vcount < SH_CNT);
        // The frame-start pixel itself is already trustworthy.
        frame_ok_s   = sync_valid_q | (h_zero_s & v_zero_s);
        sync_valid_d = sync_valid_q | (h_zero_s & v_zero_s);
        black_s      = vin.hblnk | vin.vblnk | ~h_in_s | ~v_in_s | ~frame_ok_s;
    end

    // Horizontal scaling: img_x = floor(hcount*IMG_W/SCREEN_W) via a running remainder.
    always_comb begin
        cur_xacc_s  = h_zero_s ? {ACC_W{1'b0}} : xacc_q;
        cur_img_x_s = h_zero_s ? {AW{1'b0}}    : img_x_q;
        x_sum_s     = cur_xacc_s + IW_ACC;
        if (h_in_s && v_in_s) begin
            // IMG_W <= SCREEN_W, so one subtract per pixel is always enough.
            if (x_sum_s >= SW_ACC) begin
                xacc_d  = x_sum_s - SW_ACC;
                img_x_d = cur_img_x_s + ONE_ADR;
            end else begin
                xacc_d  = x_sum_s;
                img_x_d = cur_img_x_s;
            end
        end else begin
            xacc_d  = xacc_q;
            img_x_d = img_x_q;
        end
    end

    // Vertical scaling: steps once per line at hcount==0, cleared at frame start.
    always_comb begin
        y_sum_s = yacc_q + IH_ACC;
        if (h_zero_s && v_zero_s) begin
            cur_yacc_s  = {ACC_W{1'b0}};
            cur_img_y_s = {AW{1'b0}};
            cur_row_s   = {AW{1'b0}};
        end else if (h_zero_s && v_in_s) begin
            if (y_sum_s >= SH_ACC) begin
                cur_yacc_s  = y_sum_s - SH_ACC;
                cur_img_y_s = img_y_q + ONE_ADR;
                cur_row_s   = row_base_q + IW_ADR;
            end else begin
                cur_yacc_s  = y_sum_s;
                cur_img_y_s = img_y_q;
                cur_row_s   = row_base_q;
            end
        end else begin
            cur_yacc_s  = yacc_q;
            cur_img_y_s = img_y_q;
            cur_row_s   = row_base_q;
        end
        yacc_d     = cur_yacc_s;
        img_y_d    = cur_img_y_s;
        row_base_d = cur_row_s;
    end

    // Scrolled column with wrap inside the image, and the ROM address.
    always_comb begin
        sx_sum_s = {1'b0, cur_img_x_s} + (AW + 1)'(scroll_offset_q);
        if (sx_sum_s >= IW_SX) begin
            sx_s = AW'(sx_sum_s - IW_SX);
        end else begin
            sx_s = AW'(sx_sum_s);
        end
        addr_s = cur_row_s + sx_s;
    end

`ifdef DRAW_BG_DEBUG_GRID_EN
    // Grid marker on every 32nd scrolled column and image row.
    always_comb begin
        grid_s = (sx_s[4:0] == 5'd0) | (cur_img_y_s[4:0] == 5'd0);
    end
`endif

    // Per-frame offset advance on the vblnk rising edge.
    always_comb begin
        vb_rise_s = vin.vblnk & ~vblnk_q;
        off_sum_s = {1'b0, scroll_offset_q} + STEP_OFF;
        if (vb_rise_s && scroll_en) begin
            if (off_sum_s >= IW_OFF) begin
                scroll_offset_d = OFF_W'(off_sum_s - IW_OFF);
            end else begin
                scroll_offset_d = OFF_W'(off_sum_s);
            end
        end else begin
            scroll_offset_d = scroll_offset_q;
        end
    end

    // Output pixel selection from the ROM word fetched for stage 1.
    always_comb begin
        if (black1_q) begin
            rgb2_d = 12'h000;
        end else begin
`ifdef DRAW_BG_DEBUG_GRID_EN
            rgb2_d = grid1_q ? 12'hF0F : rom_data_s;
`else
            rgb2_d = rom_data_s;
`endif
        end
    end

    // Accumulator, offset and frame-sync state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xacc_q          <= {ACC_W{1'b0}};
            img_x_q         <= {AW{1'b0}};
            yacc_q          <= {ACC_W{1'b0}};
            img_y_q         <= {AW{1'b0}};
            row_base_q      <= {AW{1'b0}};
            sync_valid_q    <= 1'b0;
            vblnk_q         <= 1'b0;
            scroll_offset_q <= {OFF_W{1'b0}};
        end else begin
            xacc_q          <= xacc_d;
            img_x_q         <= img_x_d;
            yacc_q          <= yacc_d;
            img_y_q         <= img_y_d;
            row_base_q      <= row_base_d;
            sync_valid_q    <= sync_valid_d;
            vblnk_q         <= vin.vblnk;
            scroll_offset_q <= scroll_offset_d;
        end
    end

    // Stage 1: timing fields and black flag, aligned with the ROM address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q     <= 11'd0;
            v1_q     <= 11'd0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            hb1_q    <= 1'b0;
            vb1_q    <= 1'b0;
            black1_q <= 1'b1;
`ifdef DRAW_BG_DEBUG_GRID_EN
            grid1_q  <= 1'b0;
`endif
        end else begin
            h1_q     <= vin.hcount;
            v1_q     <= vin.vcount;
            hs1_q    <= vin.hsync;
            vs1_q    <= vin.vsync;
            hb1_q    <= vin.hblnk;
            vb1_q    <= vin.vblnk;
            black1_q <= black_s;
`ifdef DRAW_BG_DEBUG_GRID_EN
            grid1_q  <= grid_s;
`endif
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h2_q   <= 11'd0;
            v2_q   <= 11'd0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            hb2_q  <= 1'b0;
            vb2_q  <= 1'b0;
            rgb2_q <= 12'h000;
        end else begin
            h2_q   <= h1_q;
            v2_q   <= v1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            hb2_q  <= hb1_q;
            vb2_q  <= vb1_q;
            rgb2_q <= rgb2_d;
        end
    end

    assign vout.hcount   = h2_q;
    assign vout.vcount   = v2_q;
    assign vout.hsync    = hs2_q;
    assign vout.vsync    = vs2_q;
    assign vout.hblnk    = hb2_q;
    assign vout.vblnk    = vb2_q;
    assign vout.rgb      = rgb2_q;
    assign scroll_offset = scroll_offset_q;

endmodule

// File: tb/tb_draw_bg_scroll.sv
// -----------------------------------------------------------------------------
// tb_draw_bg_scroll : self-checking bench for draw_bg_scroll (default params).
// A reference model computes every expected pixel with plain division and
// modulo from raster coordinates, and tracks the offset frame by frame.
// -----------------------------------------------------------------------------
module tb_draw_bg_scroll;

    localparam int SW   = 1024;
    localparam int SH   = 768;
    localparam int IW   = 320;
    localparam int IH   = 240;
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scroll_en = 1'b0;
    logic [8:0] scroll_offset;

    vga_if vin_if ();
    vga_if vout_if ();

    assign vin_if.rgb = 12'h000;

    draw_bg_scroll #(
        .SCREEN_W(SW), .SCREEN_H(SH), .IMG_W(IW), .IMG_H(IH), .SCROLL_STEP(STEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scroll_en     (scroll_en),
        .vin           (vin_if),
        .vout          (vout_if),
        .scroll_offset (scroll_offset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          h;
        int          v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        int edges;
        int h;
        int v;
        int exp_addr;
        int exp_off;
    } vec_t;

    pix_t prev_exp;
    bit   prev_valid = 1'b0;
    int   m_off      = 0;
    bit   m_prev_vb  = 1'b0;
    bit   m_synced   = 1'b0;

    function automatic logic [11:0] rom_pat(input int a);
        logic [23:0] w;
        w = 24'(a);
        return w[11:0] ^ w[23:12] ^ 12'h5A5;
    endfunction

    function automatic logic [11:0] pix_rgb(input int iy, input int sx);
`ifdef DRAW_BG_DEBUG_GRID_EN
        if ((sx % 32) == 0 || (iy % 32) == 0) return 12'hF0F;
`endif
        return rom_pat(iy * IW + sx);
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb, input bit vb);
        int ix, iy, sx;
        if (hb || vb || h >= SW || v >= SH || !m_synced) return 12'h000;
        ix = (h * IW) / SW;
        iy = (v * IH) / SH;
        sx = (ix + m_off) % IW;
        return pix_rgb(iy, sx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pixel clock: drive inputs, advance the model, compare the output
    // belonging to the pixel driven on the previous call.
    task automatic cycle(input int h, input int v, input bit hb, input bit vb, input bit en);
        pix_t e;
        e.hs = 1'($urandom_range(0, 1));
        e.vs = 1'($urandom_range(0, 1));
        vin_if.hcount = 11'(h);
        vin_if.vcount = 11'(v);
        vin_if.hsync  = e.hs;
        vin_if.vsync  = e.vs;
        vin_if.hblnk  = hb;
        vin_if.vblnk  = vb;
        scroll_en     = en;
        if (h == 0 && v == 0) m_synced = 1'b1;
        e.h = h; e.v = v; e.hb = hb; e.vb = vb;
        e.rgb = exp_rgb(h, v, hb, vb);
        @(posedge clk);
        #1;
        if (vb && !m_prev_vb && en) m_off = (m_off + STEP) % IW;
        m_prev_vb = vb;
        if (prev_valid) begin
            check("vout_timing",
                  {vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync, vout_if.hblnk, vout_if.vblnk},
                  {11'(prev_exp.h), 11'(prev_exp.v), prev_exp.hs, prev_exp.vs, prev_exp.hb, prev_exp.vb});
            check("vout_rgb", 32'(vout_if.rgb), 32'(prev_exp.rgb));
        end
        check("scroll_offset", 32'(scroll_offset), 32'(m_off));
        prev_exp   = e;
        prev_valid = 1'b1;
    endtask

    task automatic model_reset();
        m_off      = 0;
        m_prev_vb  = 1'b0;
        m_synced   = 1'b0;
        prev_valid = 1'b0;
    endtask

    task automatic do_reset();
        vin_if.hcount = 11'd1100;
        vin_if.vcount = 11'd800;
        vin_if.hsync  = 1'b0;
        vin_if.vsync  = 1'b0;
        vin_if.hblnk  = 1'b1;
        vin_if.vblnk  = 1'b0;
        scroll_en     = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_timing",
              {vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync, vout_if.hblnk, vout_if.vblnk},
              32'd0);
        check("reset_rgb", 32'(vout_if.rgb), 32'd0);
        check("reset_offset", 32'(scroll_offset), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic vblank_edge(input bit en);
        cycle(1100, 800, 1'b1, 1'b0, en);
        cycle(1100, 800, 1'b1, 1'b1, en);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{edges: 0,   h: 0,    v: 0,   exp_addr: 0,     exp_off: 0};
        tbl[1]  = '{edges: 0,   h: 1023, v: 767, exp_addr: 76799, exp_off: 0};
        tbl[2]  = '{edges: 0,   h: 3,    v: 0,   exp_addr: 0,     exp_off: 0};
        tbl[3]  = '{edges: 0,   h: 4,    v: 0,   exp_addr: 1,     exp_off: 0};
        tbl[4]  = '{edges: 0,   h: 1023, v: 0,   exp_addr: 319,   exp_off: 0};
        tbl[5]  = '{edges: 0,   h: 0,    v: 3,   exp_addr: 0,     exp_off: 0};
        tbl[6]  = '{edges: 0,   h: 0,    v: 4,   exp_addr: 320,   exp_off: 0};
        tbl[7]  = '{edges: 5,   h: 0,    v: 0,   exp_addr: 5,     exp_off: 5};
        tbl[8]  = '{edges: 320, h: 0,    v: 0,   exp_addr: 0,     exp_off: 0};
        tbl[9]  = '{edges: 319, h: 4,    v: 0,   exp_addr: 0,     exp_off: 319};
        tbl[10] = '{edges: 319, h: 3,    v: 10,  exp_addr: 1279,  exp_off: 319};

        // Table-driven corner vectors.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            for (int e = 0; e < tbl[i].edges; e++) vblank_edge(1'b1);
            cycle(1100, 800, 1'b1, 1'b0, 1'b0);
            check("tbl_offset", 32'(scroll_offset), 32'(tbl[i].exp_off));
            for (int ln = 0; ln < tbl[i].v; ln++) cycle(0, ln, 1'b0, 1'b0, 1'b0);
            for (int hh = 0; hh <= tbl[i].h; hh++) cycle(hh, tbl[i].v, 1'b0, 1'b0, 1'b0);
            cycle(1100, tbl[i].v, 1'b1, 1'b0, 1'b0);
            check("tbl_pos", {vout_if.hcount, vout_if.vcount}, {11'(tbl[i].h), 11'(tbl[i].v)});
            check("tbl_rgb", 32'(vout_if.rgb), 32'(pix_rgb(tbl[i].exp_addr / IW, tbl[i].exp_addr % IW)));
        end

        // Blanking inside the active area forces black.
        do_reset();
        for (int hh = 0; hh <= 10; hh++) cycle(hh, 0, 1'b0, 1'b0, 1'b0);
        cycle(11, 0, 1'b1, 1'b0, 1'b0);
        cycle(12, 0, 1'b0, 1'b0, 1'b0);
        check("blank_hblnk_rgb", 32'(vout_if.rgb), 32'd0);
        cycle(13, 0, 1'b0, 1'b1, 1'b0);
        cycle(14, 0, 1'b0, 1'b0, 1'b0);
        check("blank_vblnk_rgb", 32'(vout_if.rgb), 32'd0);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        repeat (3) vblank_edge(1'b1);
        cycle(1100, 800, 1'b1, 1'b0, 1'b0);
        for (int ln = 0; ln < 300; ln++) cycle(0, ln, 1'b0, 1'b0, 1'b0);
        for (int hh = 0; hh <= 500; hh++) cycle(hh, 300, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_timing",
              {vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync, vout_if.hblnk, vout_if.vblnk},
              32'd0);
        check("async_rst_rgb", 32'(vout_if.rgb), 32'd0);
        check("async_rst_offset", 32'(scroll_offset), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int hh = 501; hh < SW; hh++) cycle(hh, 300, 1'b0, 1'b0, 1'b0);
        for (int ln = 301; ln < SH; ln++) cycle(0, ln, 1'b0, 1'b0, 1'b0);
        vblank_edge(1'b1);
        cycle(1100, 800, 1'b1, 1'b0, 1'b0);
        for (int ln = 0; ln < SH; ln++) begin
            if (ln == 100) begin
                for (int hh = 0; hh < SW; hh++) cycle(hh, ln, 1'b0, 1'b0, 1'b0);
            end else begin
                for (int hh = 0; hh < 3; hh++) cycle(hh, ln, 1'b0, 1'b0, 1'b0);
            end
        end
        vblank_edge(1'b0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 3; f++) begin
            cycle(1100, 800, 1'b1, 1'b0, 1'b0);
            for (int ln = 0; ln < SH; ln++) begin
                int len;
                len = ($urandom_range(0, 127) == 0) ? SW : int'($urandom_range(1, 6));
                for (int hh = 0; hh < len; hh++)
                    cycle(hh, ln, ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
                if ($urandom_range(0, 1) == 1)
                    cycle(SW + int'($urandom_range(0, 300)), ln, 1'b1, 1'b0, 1'b0);
            end
            for (int k = 0; k < 4; k++)
                cycle(int'($urandom_range(0, 1300)), SH + k, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        cycle(1100, 800, 1'b1, 1'b0, 1'b0);
        cycle(1100, 800, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_bg_scroll.md
# draw_bg_scroll

Parametrised, horizontally scrolling background renderer for the VGA pipeline. It replaces the fixed-size background stage at the head of the draw chain. It upscales an IMG_W×IMG_H ROM image to SCREEN_W×SCREEN_H by nearest-neighbour, using incremental accumulators with no dividers. A per-frame scroll offset, advanced at the start of vertical blanking, wraps the image horizontally to give the flappy-bird side-scroll.

## Interface
- SCREEN_W, 1024: active pixels per line.
- SCREEN_H, 768: active lines per frame.
- IMG_W, 320: ROM image width. Must satisfy 1 ≤ IMG_W ≤ SCREEN_W.
- IMG_H, 240: ROM image height. Must satisfy 1 ≤ IMG_H ≤ SCREEN_H.
- SCROLL_STEP, 1: image pixels advanced per frame. Must satisfy 0 ≤ SCROLL_STEP < IMG_W.
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- scroll_en  in  1  enables the per-frame offset advance. Sampled at the vblnk rising edge.
- vin  vga_if.in  –  timing input: hcount, vcount, hsync, vsync, hblnk, vblnk. Widths per vga_pkg.
- vout  vga_if.out  –  delayed timing plus rgb[11:0].
- scroll_offset  out  $clog2(IMG_W)  current horizontal offset, in image pixels.

## Operation
- **Internal ROM.** image_rom #(.WIDTH(IMG_W), .HEIGHT(IMG_H)), 1-cycle registered read. Address width is $clog2(IMG_W*IMG_H).
- **Horizontal scaling.** img_x = floor(hcount·IMG_W/SCREEN_W) for hcount < SCREEN_W.
  - Realised with an x-accumulator cleared when hcount==0.
  - Each subsequent pixel adds IMG_W. When the sum reaches ≥ SCREEN_W, subtract SCREEN_W and increment img_x.
- **Vertical scaling.** img_y = floor(vcount·IMG_H/SCREEN_H), with the same scheme.
  - The y-accumulator steps once per line at hcount==0. It is cleared at hcount==0 && vcount==0.
  - row_base (= img_y·IMG_W) is accumulated by adding IMG_W on each img_y increment. No multiplier.
- **Scroll.** sx = img_x + scroll_offset; if sx ≥ IMG_W, sx -= IMG_W. Address = row_base + sx.
- **Offset update.** On a detected rising edge of vin.vblnk (previous-cycle vblnk register), if scroll_en=1:
  - scroll_offset ← (scroll_offset + SCROLL_STEP) mod IMG_W, computed as a conditional subtract.
  - Offset is therefore constant throughout every visible frame.
- **Blanking.** During hblnk or vblnk, ROM output is ignored and vout.rgb = 12'h000.
- **Out-of-range pixels.** hcount ≥ SCREEN_W or vcount ≥ SCREEN_H while not blanked: rgb = 12'h000, and accumulators do not advance.

## Timing
- **Latency.** 2 cycles, vin → vout, for every field.
  - Stage 1 registers the ROM address plus blank/sync/count.
  - Stage 2 registers rgb with the ROM data plus the delayed fields.
- **Reset.** rst=1 asynchronously clears:
  - all vout fields (hcount, vcount, syncs, blanks, rgb) to 0;
  - scroll_offset, accumulators, img_x/img_y, row_base and the vblnk edge register to 0.
- **Reset mid-frame.** Output stays at 0 until the next hcount==0 / vcount==0 resynchronises the accumulators. Garbage rgb must not appear outside blanking; force black until the first vcount==0 line after reset.
- **Simultaneous events.**
  - hcount==0 and vcount==0 in the same cycle: both accumulators clear.
  - vblnk rising with scroll_en toggling in that cycle: the sampled value of scroll_en is used.
- **Wrap-around.** scroll_offset wraps IMG_W-1 → 0 (or to the modular result). sx wraps within a line with no gap pixel.

## Configuration
- **DRAW_BG_DEBUG_GRID_EN defined:** non-blanked pixels whose sx[4:0]==0 or img_y[4:0]==0 output 12'hF0F instead of ROM data. Latency is unchanged.
- **Not defined:** pure ROM output. No grid logic is synthesised.

## Test plan
- **Static corners.** scroll_en=0, default params:
  - (hcount,vcount)=(0,0) → ROM addr 0.
  - (1023,767) → addr 239·320+319 = 76799.
  - vout fields equal vin delayed by exactly 2 cycles.
- **Scaling steps.**
  - hcount=3 → img_x 0; hcount=4 → img_x 1; hcount=1023 → 319.
  - vcount=3 → img_y 0; vcount=4 → img_y 1.
  - Matches a divide-based reference model over a full frame.
- **Scroll and wrap.** scroll_en=1, SCROLL_STEP=1:
  - after 5 vblnk edges, scroll_offset=5, and hcount=0 reads img x 5;
  - after 320 edges, scroll_offset=0;
  - with offset 319, hcount=4 → sx 0.
- **Blanking.** hblnk=1 or vblnk=1 with non-zero ROM data → vout.rgb=12'h000 two cycles later.
- **Async reset mid-frame.** Assert rst at hcount=500, vcount=300:
  - all outputs 0 within the same cycle and scroll_offset=0;
  - rgb stays black until the next frame starts, then the image is correct.
- **Debug grid.** With DRAW_BG_DEBUG_GRID_EN, offset 0: hcount=0 → rgb F0F; hcount=4 (img_x 1, img_y≠0 mod 32) → ROM data.
